// File: rtl/base3_pkg.sv
// ---------------------------------------------------------------------------
// base3_pkg
// Shared definitions for the ternary-to-binary converter.
//   state_e        : converter FSM states (IDLE, EXEC, DONE)
//   DIGIT_W        : bits per packed base-3 digit
//   DIGIT_ILLEGAL  : the one 2-bit code that is not a valid ternary digit
// ---------------------------------------------------------------------------
package base3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          DIGIT_W       = 2;
  localparam logic [1:0]  DIGIT_ILLEGAL = 2'b11;

endpackage : base3_pkg

// File: rtl/base3_digit_mac.sv
// ---------------------------------------------------------------------------
// base3_digit_mac
// One Horner step of base-3 evaluation: acc_o = 3*acc_i + digit_i.
// Purely combinational.
// Ports:
//   acc_i       in  ACC_W    running accumulator
//   digit_i     in  DIGIT_W  current ternary digit (2'b11 is illegal)
//   acc_o       out ACC_W    updated accumulator
//   bad_digit_o out 1        digit_i was the illegal code
// ---------------------------------------------------------------------------
module base3_digit_mac
  import base3_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [ACC_W-1:0]   acc_o,
  output logic               bad_digit_o
);

  logic [DIGIT_W-1:0] digitEff;

  // An illegal digit is flagged and treated as zero so the sum stays meaningful.
  always_comb begin
    bad_digit_o = (digit_i == DIGIT_ILLEGAL);
    digitEff    = bad_digit_o ? '0 : digit_i;
    acc_o       = (acc_i << 1) + acc_i + ACC_W'(digitEff);
  end

endmodule : base3_digit_mac

// File: rtl/base3_to_base2.sv
// ---------------------------------------------------------------------------
// base3_to_base2
// Multi-cycle packed base-3 to unsigned binary converter. Digits are consumed
// MSB first, one per clock, using Horner evaluation (acc = 3*acc + digit).
// Ports:
//   clk       in  1           clock, rising edge
//   rst_n     in  1           asynchronous active-low reset
//   base3_no  in  2*N_DIGITS  packed ternary input, digit k at [2k+1:2k]
//   en        in  1           start request, only looked at while idle
//   base2_no  out OUT_W       low OUT_W bits of the converted value
//   ovf       out 1           converted value does not fit in OUT_W bits
//   err       out 1           at least one digit was 2'b11
//   done      out 1           one-cycle pulse when results are updated
// ---------------------------------------------------------------------------
module base3_to_base2
  import base3_pkg::*;
#(
  parameter int N_DIGITS = 16,
  parameter int OUT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2*N_DIGITS-1:0]   base3_no,
  input  logic                    en,
  output logic [OUT_W-1:0]        base2_no,
  output logic                    ovf,
  output logic                    err,
  output logic                    done
);

  // 2 bits per digit is always enough headroom: 3^N < 4^N, so acc never wraps.
  localparam int ACC_W = 2 * N_DIGITS;
  localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  state_e              state_q,  state_d;
  logic [ACC_W-1:0]    shadow_q, shadow_d;
  logic [ACC_W-1:0]    acc_q,    acc_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic                errAcc_q, errAcc_d;
  logic [OUT_W-1:0]    base2_q,  base2_d;
  logic                ovf_q,    ovf_d;
  logic                err_q,    err_d;
  logic                done_q,   done_d;

  logic [DIGIT_W-1:0]  curDigit;
  logic [ACC_W-1:0]    macAcc;
  logic                macBad;

  // Digit selected by the down-counter from the latched copy of the input.
  assign curDigit = shadow_q[{cnt_q, 1'b0} +: DIGIT_W];

  base3_digit_mac #(
    .ACC_W (ACC_W)
  ) u_mac (
    .acc_i       (acc_q),
    .digit_i     (curDigit),
    .acc_o       (macAcc),
    .bad_digit_o (macBad)
  );

  // Next-state logic. Results are only loaded on the last EXEC step, so the
  // outputs hold the previous conversion throughout a new one.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    errAcc_d = errAcc_q;
    base2_d  = base2_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          shadow_d = base3_no;
          acc_d    = '0;
          errAcc_d = 1'b0;
          cnt_d    = CNT_W'(N_DIGITS - 1);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        acc_d    = macAcc;
        errAcc_d = errAcc_q | macBad;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          base2_d = macAcc[OUT_W-1:0];
          ovf_d   = |macAcc[ACC_W-1:OUT_W];
          err_d   = errAcc_q | macBad;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      errAcc_q <= 1'b0;
      base2_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      errAcc_q <= errAcc_d;
      base2_q  <= base2_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign base2_no = base2_q;
  assign ovf      = ovf_q;
  assign err      = err_q;
  assign done     = done_q;

endmodule : base3_to_base2

// File: tb/tb_base3_to_base2.sv
// ---------------------------------------------------------------------------
// tb_base3_to_base2
// Directed self-checking bench for base3_to_base2 (default parameters).
// ---------------------------------------------------------------------------
module tb_base3_to_base2;

  logic        clk;
  logic        rst_n;
  logic [31:0] base3_no;
  logic        en;
  logic [15:0] base2_no;
  logic        ovf;
  logic        err;
  logic        done;

  int compared   = 0;
  int mismatched = 0;

  base3_to_base2 #(
    .N_DIGITS (16),
    .OUT_W    (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .base3_no (base3_no),
    .en       (en),
    .base2_no (base2_no),
    .ovf      (ovf),
    .err      (err),
    .done     (done)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and on mismatch count and report it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Forward converter: binary value to packed base-3 digits, LSB digit first.
  function automatic logic [31:0] toBase3(input int unsigned value);
    logic [31:0] packed3;
    int unsigned v;
    packed3 = '0;
    v = value;
    for (int k = 0; k < 16; k++) begin
      packed3[2*k +: 2] = 2'(v % 3);
      v = v / 3;
    end
    return packed3;
  endfunction

  // Start a conversion with a one-cycle en pulse and wait for done.
  // 'edges' counts rising edges with the en-sampling edge as edge 1.
  task automatic applyStimulus(input logic [31:0] value, output int edges);
    @(negedge clk);
    base3_no = value;
    en       = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    en = 1'b0;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic runAndCheck(input string tag, input logic [31:0] value,
                             input logic [15:0] expBase2, input logic expOvf,
                             input logic expErr);
    int edges;
    applyStimulus(value, edges);
    checkOutput({tag, "_latency"}, 32'(edges), 32'd17);
    checkOutput({tag, "_base2"}, {16'h0, base2_no}, {16'h0, expBase2});
    checkOutput({tag, "_ovf"}, {31'h0, ovf}, {31'h0, expOvf});
    checkOutput({tag, "_err"}, {31'h0, err}, {31'h0, expErr});
  endtask

  initial begin
    int edges;
    int donePulses;
    int firstDone;
    int secondDone;
    logic [15:0] rv;

    rst_n    = 1'b0;
    en       = 1'b0;
    base3_no = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_base2", {16'h0, base2_no}, 32'h0);
    checkOutput("reset_flags", {29'h0, ovf, err, done}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // "12" in base 3 is 5
    runAndCheck("t1", 32'h0000_0006, 16'd5, 1'b0, 1'b0);
    // done lasts exactly one cycle and results hold afterwards
    @(negedge clk);
    checkOutput("t1_done_width", {31'h0, done}, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("t1_hold", {16'h0, base2_no}, 32'd5);

    // 65535 fits, 65536 overflows to 0
    runAndCheck("t2a", 32'h0010_AA08, 16'hFFFF, 1'b0, 1'b0);
    runAndCheck("t2b", 32'h0010_AA09, 16'h0000, 1'b1, 1'b0);

    // 3^16-1 = 43046720 = 0x290_D740
    runAndCheck("t3", 32'hAAAA_AAAA, 16'hD740, 1'b1, 1'b0);

    // all-zero input still takes full latency
    runAndCheck("zero", 32'h0000_0000, 16'h0000, 1'b0, 1'b0);

    // illegal digits, then a legal run clears err
    runAndCheck("t4a", 32'h0000_000F, 16'h0000, 1'b0, 1'b1);
    // digits (hi..lo) 1,3,2 -> 1*9 + 0*3 + 2 = 11 with err
    runAndCheck("t4b", 32'h0000_001E, 16'd11, 1'b0, 1'b1);
    runAndCheck("t4c", 32'h0000_0006, 16'd5, 1'b0, 1'b0);

    // input change and en pulse during EXEC are ignored
    @(negedge clk);
    base3_no = 32'h0000_0009;   // "21" = 7
    en       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    base3_no = 32'hAAAA_AAAA;
    en       = 1'b1;
    @(negedge clk);
    en = 1'b0;
    edges = 4;
    while (done !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("t5_latency", 32'(edges), 32'd17);
    checkOutput("t5_base2", {16'h0, base2_no}, 32'd7);
    checkOutput("t5_ovf", {31'h0, ovf}, 32'h0);
    donePulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) donePulses++;
    end
    checkOutput("t5_single_done", 32'(donePulses), 32'd0);

    // reset in the middle of EXEC
    @(negedge clk);
    base3_no = 32'h0000_0006;
    en       = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_base2", {16'h0, base2_no}, 32'h0);
    checkOutput("t6_rst_flags", {29'h0, ovf, err, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    donePulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) donePulses++;
    end
    checkOutput("t6_no_done", 32'(donePulses), 32'd0);
    runAndCheck("t6_after", 32'h0000_0009, 16'd7, 1'b0, 1'b0);

    // en held high: back-to-back conversions every 18 cycles
    @(negedge clk);
    base3_no   = 32'h0000_0006;
    en         = 1'b1;
    firstDone  = -1;
    secondDone = -1;
    for (int cyc = 1; cyc <= 60 && secondDone < 0; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (firstDone < 0) firstDone = cyc;
        else secondDone = cyc;
      end
    end
    en = 1'b0;
    checkOutput("held_first", 32'(firstDone), 32'd17);
    checkOutput("held_period", 32'(secondDone - firstDone), 32'd18);
    repeat (3) @(negedge clk);

    // round trip against the forward conversion
    for (int i = 0; i < 4; i++) begin
      rv = 16'($urandom_range(0, 65535));
      runAndCheck($sformatf("rt%0d", i), toBase3(32'(rv)), rv, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_base3_to_base2
